oled_iic_writer: RTL and testbench

//  Consumes the 24-bit word stream built by the OLED font/command stages:
//    {dev_addr[23:16], ctrl[15:8], data[7:0]}.

---
 rtl/oled_iic_writer_if.sv | 32 +++
 rtl/oled_iic_writer.sv | 213 +++++++++++++++++++++
 tb/tb_oled_iic_writer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_iic_writer_if.sv
`timescale 1ns/1ps
// oled_iic_writer_if
//   Word handshake between the OLED content generators (master side) and the
//   I2C writer (slave side).
//   write_req   master -> slave  level request, write_data valid while high
//   write_data  master -> slave  {dev_addr, ctrl, data}
//   write_done  slave -> master  one-cycle pulse when a word has been sent
//   busy        slave -> master  high while a word is in flight
//   ack_err     slave -> master  sticky NACK flag for the last accepted word
interface oled_iic_writer_if;
  logic        write_req;
  logic [23:0] write_data;
  logic        write_done;
  logic        busy;
  logic        ack_err;

  modport master (
    output write_req,
    output write_data,
    input  write_done,
    input  busy,
    input  ack_err
  );

  modport slave (
    input  write_req,
    input  write_data,
    output write_done,
    output busy,
    output ack_err
  );
endinterface

// File: rtl/oled_iic_writer.sv
`timescale 1ns/1ps
// oled_iic_writer
//   Sends each 24-bit word {dev_addr, ctrl, data} from the OLED font/command
//   stages as one 3-byte I2C write (START, 3 bytes each followed by an ACK
//   slot, STOP) and pulses write_done once per word.
//   Each I2C bit is split into four quarter-periods (q0..q3) of TICK_DIV
//   sys_clk cycles each.
// Ports
//   sys_clk  system clock
//   rst      asynchronous, active-high reset
//   wr       word handshake (write_req/write_data in, write_done/busy/ack_err out)
//   iic_scl  SCL, driven high or low, idle high
//   iic_sda  SDA, open-drain: driven low or released (external pull-up)
module oled_iic_writer #(
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int IIC_FREQ     = 400_000,
  parameter int TICK_DIV     = SYS_CLK_FREQ / (IIC_FREQ * 4)
) (
  input  logic             sys_clk,
  input  logic             rst,
  oled_iic_writer_if.slave wr,
  output logic             iic_scl,
  inout  wire              iic_sda
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BYTE,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_n;
  logic [1:0]        q, q_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic              scl, scl_n;
  logic              sda_oe, sda_oe_n;
  logic              ack_err, ack_err_n;
  logic [23:0]       shift, shift_n;
  logic              sda_p0, sda_p1;
  logic              tick;

  assign iic_sda       = sda_oe ? 1'b0 : 1'bz;
  assign iic_scl       = scl;
  assign wr.write_done = (state == S_DONE);
  assign wr.busy       = (state != S_IDLE);
  assign wr.ack_err    = ack_err;
  assign tick          = (state != S_IDLE) && (tick_cnt == TICK_LAST);

  // Stage p0/p1: two-flop synchronizer for the SDA pin read back in the ACK slot
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      sda_p0 <= iic_sda;
      sda_p1 <= sda_p0;
    end
  end

  // State register: control and bus pins
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      q        <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      q        <= q_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      scl      <= scl_n;
      sda_oe   <= sda_oe_n;
      ack_err  <= ack_err_n;
    end
  end

  // Data register: shift register, loaded only at acceptance
  always_ff @(posedge sys_clk) begin
    shift <= shift_n;
  end

  // Next-state and bus-level decode. Pin levels for a quarter are set on the
  // tick that enters that quarter, so the case on q names the quarter ending.
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    q_n        = q;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    scl_n      = scl;
    sda_oe_n   = sda_oe;
    ack_err_n  = ack_err;
    shift_n    = shift;

    if (state != S_IDLE) begin
      tick_cnt_n = tick ? '0 : tick_cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        scl_n    = 1'b1;
        sda_oe_n = 1'b0;
        if (wr.write_req) begin
          state_n    = S_START;
          shift_n    = wr.write_data;
          ack_err_n  = 1'b0;
          tick_cnt_n = '0;
          q_n        = 2'd0;
          bit_cnt_n  = 3'd0;
          byte_cnt_n = 2'd0;
        end
      end

      S_START: begin
        if (tick) begin
          q_n = q + 2'd1;
          case (q)
            2'd0: sda_oe_n = 1'b1;          // SDA falls while SCL high
            2'd2: scl_n    = 1'b0;
            2'd3: begin
              state_n  = S_BYTE;
              sda_oe_n = ~shift[23];
            end
            default: ;
          endcase
        end
      end

      S_BYTE: begin
        if (tick) begin
          q_n = q + 2'd1;
          case (q)
            2'd0: scl_n = 1'b1;
            2'd2: begin
              scl_n   = 1'b0;
              shift_n = {shift[22:0], 1'b0};
            end
            2'd3: begin
              if (bit_cnt == 3'd7) begin
                state_n   = S_ACK;
                bit_cnt_n = 3'd0;
                sda_oe_n  = 1'b0;             // release SDA for the slave
              end else begin
                bit_cnt_n = bit_cnt + 3'd1;
                sda_oe_n  = ~shift[23];
              end
            end
            default: ;
          endcase
        end
      end

      S_ACK: begin
        if (tick) begin
          q_n = q + 2'd1;
          case (q)
            2'd0: scl_n = 1'b1;
            2'd1: begin
              if (sda_p1) ack_err_n = 1'b1;   // high in the ACK slot is a NACK
            end
            2'd2: scl_n = 1'b0;
            2'd3: begin
              // After a NACK the remaining bytes are skipped.
              if (ack_err || byte_cnt == 2'd2) begin
                state_n  = S_STOP;
                sda_oe_n = 1'b1;
              end else begin
                state_n    = S_BYTE;
                byte_cnt_n = byte_cnt + 2'd1;
                sda_oe_n   = ~shift[23];
              end
            end
            default: ;
          endcase
        end
      end

      S_STOP: begin
        if (tick) begin
          q_n = q + 2'd1;
          case (q)
            2'd0: scl_n    = 1'b1;
            2'd1: sda_oe_n = 1'b0;          // SDA rises while SCL high
            2'd3: state_n  = S_DONE;
            default: ;
          endcase
        end
      end

      S_DONE: begin
        state_n    = S_IDLE;
        tick_cnt_n = '0;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oled_iic_writer.sv
`timescale 1ns/1ps
// tb_oled_iic_writer
//   Drives oled_iic_writer through its word handshake, acts as an I2C slave
//   (decodes START/STOP/bytes, answers ACK or NACK per byte) and compares the
//   bus traffic, timing and flags with expectations derived from the transfer
//   rules: a word is START + up to 3 bytes of 9 bits + STOP, 4 ticks each.
module tb_oled_iic_writer;

  localparam int TICK_DIV = 31;

  logic sys_clk;
  logic rst;
  logic iic_scl;
  wire  iic_sda;
  logic slave_low;
  logic [3:0] slv_mask;

  oled_iic_writer_if wr();

  pullup (iic_sda);
  assign iic_sda = slave_low ? 1'b0 : 1'bz;
  wire sda_bit = (iic_sda !== 1'b0);

  oled_iic_writer #(
    .SYS_CLK_FREQ(50_000_000),
    .IIC_FREQ    (400_000)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .wr     (wr),
    .iic_scl(iic_scl),
    .iic_sda(iic_sda)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // I2C slave / bus monitor
  logic       scl_prev, sda_prev, in_frame;
  int         bitcnt, start_cnt, stop_cnt;
  logic [1:0] byte_idx;
  logic [7:0] sh;
  logic [7:0] rx_q[$];

  always @(negedge sys_clk) begin
    if (rst) begin
      in_frame  <= 1'b0;
      slave_low <= 1'b0;
      bitcnt    <= 0;
      byte_idx  <= 2'd0;
      start_cnt <= 0;
      stop_cnt  <= 0;
      rx_q.delete();
    end else begin
      if (scl_prev && iic_scl && sda_prev && !sda_bit) begin
        start_cnt <= start_cnt + 1;
        in_frame  <= 1'b1;
        bitcnt    <= 0;
        byte_idx  <= 2'd0;
      end else if (scl_prev && iic_scl && !sda_prev && sda_bit) begin
        stop_cnt <= stop_cnt + 1;
        in_frame <= 1'b0;
      end else if (in_frame && !scl_prev && iic_scl) begin
        if (bitcnt < 8) sh <= {sh[6:0], sda_bit};
        bitcnt <= bitcnt + 1;
      end else if (in_frame && scl_prev && !iic_scl) begin
        if (bitcnt == 8) begin
          rx_q.push_back(sh);
          slave_low <= ~slv_mask[byte_idx];
        end else if (bitcnt == 9) begin
          slave_low <= 1'b0;
          bitcnt    <= 0;
          byte_idx  <= byte_idx + 2'd1;
        end
      end
    end
    scl_prev <= iic_scl;
    sda_prev <= sda_bit;
  end

  int checks;
  int errors;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: bytes reached before the first NACK, and word duration.
  function automatic int model_nbytes(input logic [2:0] m);
    if (m[0]) return 1;
    if (m[1]) return 2;
    return 3;
  endfunction

  function automatic int model_lat(input int nb);
    return (4 + nb * 9 * 4 + 4) * TICK_DIV + 1;
  endfunction

  task automatic run_word(input string name, input logic [23:0] w, input logic [2:0] m,
                          input bit scramble, input logic exp_err, input int exp_nb,
                          input int exp_lat);
    int s0, st0, sp0, n, cnt;
    bit seen;
    logic [23:0] got, expb;
    slv_mask = {1'b0, m};
    s0  = rx_q.size();
    st0 = start_cnt;
    sp0 = stop_cnt;
    @(negedge sys_clk);
    wr.write_req  = 1'b1;
    wr.write_data = w;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (wr.busy) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_accept"}, 64'(seen), 64'd1);
    wr.write_req = 1'b0;
    if (!seen) return;
    check({name, "_err_clear"}, 64'(wr.ack_err), 64'd0);
    if (scramble) wr.write_data = ~w ^ 24'h5A5A5A;
    n = 0;
    seen = 1'b0;
    while (n < 10000 && !seen) begin
      @(negedge sys_clk);
      n++;
      if (wr.write_done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    check({name, "_latency"}, 64'(n + 1), 64'(exp_lat));
    check({name, "_ack_err"}, 64'(wr.ack_err), 64'(exp_err));
    @(negedge sys_clk);
    check({name, "_pulse_end"}, 64'({wr.write_done, wr.busy}), 64'd0);
    cnt = rx_q.size() - s0;
    got = '0;
    for (int i = 0; i < cnt && i < 3; i++) got[23 - 8 * i -: 8] = rx_q[s0 + i];
    expb = w & (24'hFFFFFF << (8 * (3 - exp_nb)));
    check({name, "_nbytes"}, 64'(cnt), 64'(exp_nb));
    check({name, "_bytes"}, 64'(got), 64'(expb));
    check({name, "_start_stop"}, 64'((start_cnt - st0) * 256 + (stop_cnt - sp0)), 64'd257);
  endtask

  typedef struct {
    logic [23:0] word;
    logic [2:0]  nack;
    logic        exp_err;
    int          exp_nb;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];
  logic [23:0] b2b[3];

  initial begin
    int gap, n, bad, nb;
    bit seen;
    int s0, st0, sp0;
    logic [23:0] w;
    logic [2:0] m;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    wr.write_req  = 1'b0;
    wr.write_data = '0;
    slv_mask = 4'd0;

    vecs[0] = '{24'h7800B0, 3'b000, 1'b0, 3, 3597};
    vecs[1] = '{24'h7800B0, 3'b001, 1'b1, 1, 1365};
    vecs[2] = '{24'h7840FF, 3'b010, 1'b1, 2, 2481};
    vecs[3] = '{24'h3C805A, 3'b100, 1'b1, 3, 3597};
    vecs[4] = '{24'hFFFFFF, 3'b000, 1'b0, 3, 3597};
    vecs[5] = '{24'h000000, 3'b000, 1'b0, 3, 3597};

    repeat (3) @(negedge sys_clk);
    check("rst_scl", 64'(iic_scl), 64'd1);
    check("rst_sda", 64'(sda_bit), 64'd1);
    check("rst_busy", 64'(wr.busy), 64'd0);
    check("rst_done", 64'(wr.write_done), 64'd0);
    check("rst_ack_err", 64'(wr.ack_err), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    for (int v = 0; v < 6; v++)
      run_word($sformatf("vec%0d", v), vecs[v].word, vecs[v].nack, 1'b0,
               vecs[v].exp_err, vecs[v].exp_nb, vecs[v].exp_lat);

    // Back-to-back words with write_req held high
    b2b[0] = 24'h7800B3;
    b2b[1] = 24'h780000;
    b2b[2] = 24'h7840FF;
    slv_mask = 4'd0;
    s0  = rx_q.size();
    st0 = start_cnt;
    sp0 = stop_cnt;
    @(negedge sys_clk);
    wr.write_req  = 1'b1;
    wr.write_data = b2b[0];
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge sys_clk);
        if (wr.busy) begin
          seen = 1'b1;
          break;
        end
        gap++;
      end
      check($sformatf("b2b%0d_accept", k), 64'(seen), 64'd1);
      if (k > 0) check($sformatf("b2b%0d_idle_gap", k), 64'(gap), 64'd1);
      n = 0;
      seen = 1'b0;
      while (n < 10000 && !seen) begin
        @(negedge sys_clk);
        n++;
        if (wr.write_done) seen = 1'b1;
      end
      check($sformatf("b2b%0d_latency", k), 64'(n + 1), 64'(model_lat(3)));
      if (k < 2) wr.write_data = b2b[k + 1];
      else wr.write_req = 1'b0;
    end
    repeat (2) @(negedge sys_clk);
    check("b2b_nbytes", 64'(rx_q.size() - s0), 64'd9);
    for (int j = 0; j < 9 && s0 + j < rx_q.size(); j++)
      check($sformatf("b2b_byte%0d", j), 64'(rx_q[s0 + j]), 64'(b2b[j / 3][23 - 8 * (j % 3) -: 8]));
    check("b2b_start_stop", 64'((start_cnt - st0) * 256 + (stop_cnt - sp0)), 64'd771);
    check("b2b_ack_err", 64'(wr.ack_err), 64'd0);

    // Reset in the middle of the ctrl byte
    slv_mask = 4'd0;
    @(negedge sys_clk);
    wr.write_req  = 1'b1;
    wr.write_data = 24'h7840A5;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (wr.busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_rst_accept", 64'(seen), 64'd1);
    wr.write_req = 1'b0;
    repeat (58 * TICK_DIV) @(negedge sys_clk);
    rst = 1'b1;
    #1;
    check("mid_rst_scl", 64'(iic_scl), 64'd1);
    check("mid_rst_sda", 64'(sda_bit), 64'd1);
    check("mid_rst_busy", 64'(wr.busy), 64'd0);
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    run_word("after_rst", 24'h7800AF, 3'b000, 1'b0, 1'b0, 3, model_lat(3));

    // Idle bus with no request
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if (!iic_scl || !sda_bit || wr.write_done || wr.busy) bad++;
    end
    check("idle_1000", 64'(bad), 64'd0);

    // Random words and ACK patterns, some with write_data changed mid-transfer
    for (int r = 0; r < 6; r++) begin
      w = 24'($urandom);
      m = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) m = 3'b000;
      nb = model_nbytes(m);
      run_word($sformatf("rnd%0d", r), w, m, r[0], (m != 3'b000), nb, model_lat(nb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
